// File: rtl/register.sv
// Y86-64 architectural register file for the sequential processor.
// Fifteen 64-bit registers with two combinational read ports (valA/valB) and
// two write ports (valE/valM) committed on the rising clock edge. Register
// IDs are decoded from icode/rA/rB/cnd inside this block.
module register (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  icode,
    input  logic        cnd,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    output logic [63:0] valA,
    output logic [63:0] valB
);

    // Instruction codes used by the decoder.
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // Special register IDs. RNONE never matches a storage slot, so a read of
    // it returns 0 and a write to it is silently dropped.
    localparam logic [3:0] RSP   = 4'h4;
    localparam logic [3:0] RNONE = 4'hF;

    localparam int NREGS = 15;

    logic [63:0] r_regs [NREGS];

    logic [3:0] w_srcA;
    logic [3:0] w_srcB;
    logic [3:0] w_dstE;
    logic [3:0] w_dstM;

    // Decode the four register IDs from the instruction fields.
    always_comb begin
        w_srcA = RNONE;
        w_srcB = RNONE;
        w_dstE = RNONE;
        w_dstM = RNONE;

        case (icode)
            I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: w_srcA = rA;
            I_RET, I_POPQ:                      w_srcA = RSP;
            default:                            w_srcA = RNONE;
        endcase

        case (icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ:           w_srcB = rB;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:      w_srcB = RSP;
            default:                             w_srcB = RNONE;
        endcase

        case (icode)
            I_RRMOVQ:                            w_dstE = cnd ? rB : RNONE;
            I_IRMOVQ, I_OPQ:                     w_dstE = rB;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:      w_dstE = RSP;
            default:                             w_dstE = RNONE;
        endcase

        case (icode)
            I_MRMOVQ, I_POPQ:                    w_dstM = rA;
            default:                             w_dstM = RNONE;
        endcase
    end

    // Read ports: select by comparing against each slot so RNONE yields 0
    // without ever indexing past the end of the array.
    always_comb begin
        valA = '0;
        valB = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (w_srcA == 4'(i)) valA = r_regs[i];
            if (w_srcB == 4'(i)) valB = r_regs[i];
        end
    end

    // Write ports: valM takes priority when both ports target the same
    // register (popq %rsp); reset clears everything and overrides writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (w_dstM == 4'(i)) begin
                    r_regs[i] <= valM;
                end else if (w_dstE == 4'(i)) begin
                    r_regs[i] <= valE;
                end
            end
        end
    end

endmodule

// File: tb/tb_register.sv
// Directed testbench for the Y86-64 register file. Each scenario task drives
// instructions on the falling edge and checks the combinational read ports
// shortly after, so every rising edge in between commits the previous
// instruction's writes.
module tb_register;

    logic        clk;
    logic        reset;
    logic [3:0]  icode;
    logic        cnd;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valE;
    logic [63:0] valM;
    logic [63:0] valA;
    logic [63:0] valB;

    int total = 0;
    int bad   = 0;

    localparam logic [63:0] E0 = 64'h3424867AEC;

    register dut (
        .clk   (clk),
        .reset (reset),
        .icode (icode),
        .cnd   (cnd),
        .rA    (rA),
        .rB    (rB),
        .valE  (valE),
        .valM  (valM),
        .valA  (valA),
        .valB  (valB)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one instruction on the falling edge and let the reads settle.
    task automatic applyStimulus(input logic [3:0] ic, input logic c,
                                 input logic [3:0] a, input logic [3:0] b,
                                 input logic [63:0] e, input logic [63:0] m);
        @(negedge clk);
        icode = ic;
        cnd   = c;
        rA    = a;
        rB    = b;
        valE  = e;
        valM  = m;
        #1;
    endtask

    // Reset clears all registers; reads under several decodes are zero.
    task automatic test_reset();
        reset = 1'b1;
        icode = 4'hB; cnd = 1'b0; rA = 4'h2; rB = 4'h7; valE = '0; valM = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (valA !== 64'h0) begin bad++; $display("[TB] FAIL reset_popq_valA got=%h exp=%h", valA, 64'h0); end
        total++;
        if (valB !== 64'h0) begin bad++; $display("[TB] FAIL reset_popq_valB got=%h exp=%h", valB, 64'h0); end
        applyStimulus(4'h4, 1'b0, 4'h1, 4'h2, 64'h0, 64'h0);
        total++;
        if (valA !== 64'h0 || valB !== 64'h0) begin
            bad++; $display("[TB] FAIL reset_rmmovq got=%h/%h exp=0/0", valA, valB);
        end
        reset = 1'b0;
    endtask

    // popq writes R4 from valE and rA from valM; reads track the previous edge.
    task automatic test_popq();
        applyStimulus(4'hB, 1'b0, 4'h2, 4'h7, E0, 64'h6567);
        total++;
        if (valA !== 64'h0 || valB !== 64'h0) begin
            bad++; $display("[TB] FAIL popq_before_edge got=%h/%h exp=0/0", valA, valB);
        end
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(4'hB, 1'b0, 4'h2, 4'h7, E0 + 64'(k), 64'h6567);
            total++;
            if (valA !== E0 + 64'(k - 1) || valB !== E0 + 64'(k - 1)) begin
                bad++;
                $display("[TB] FAIL popq_track_%0d got=%h/%h exp=%h", k, valA, valB, E0 + 64'(k - 1));
            end
        end
        applyStimulus(4'h4, 1'b0, 4'h2, 4'h4, 64'h0, 64'h0);
        total++;
        if (valA !== 64'h6567) begin bad++; $display("[TB] FAIL popq_R2 got=%h exp=%h", valA, 64'h6567); end
        total++;
        if (valB !== E0 + 64'd3) begin bad++; $display("[TB] FAIL popq_R4 got=%h exp=%h", valB, E0 + 64'd3); end
    endtask

    // irmovq loads R1; OPq then reads it through both ports.
    task automatic test_irmovq_opq();
        applyStimulus(4'h3, 1'b0, 4'hF, 4'h1, 64'h11, 64'h0);
        total++;
        if (valA !== 64'h0 || valB !== 64'h0) begin
            bad++; $display("[TB] FAIL irmovq_no_read got=%h/%h exp=0/0", valA, valB);
        end
        applyStimulus(4'h6, 1'b0, 4'h1, 4'h1, 64'h11, 64'h0);
        total++;
        if (valA !== 64'h11 || valB !== 64'h11) begin
            bad++; $display("[TB] FAIL opq_read_R1 got=%h/%h exp=11/11", valA, valB);
        end
    endtask

    // cmov writes rB only when cnd is set.
    task automatic test_cmov();
        applyStimulus(4'h2, 1'b0, 4'h1, 4'h3, 64'h55, 64'h0);
        total++;
        if (valA !== 64'h11) begin bad++; $display("[TB] FAIL cmov_srcA got=%h exp=%h", valA, 64'h11); end
        applyStimulus(4'h4, 1'b0, 4'h3, 4'h1, 64'h0, 64'h0);
        total++;
        if (valA !== 64'h0) begin bad++; $display("[TB] FAIL cmov_cnd0_R3 got=%h exp=%h", valA, 64'h0); end
        applyStimulus(4'h2, 1'b1, 4'h1, 4'h3, 64'h55, 64'h0);
        applyStimulus(4'h4, 1'b0, 4'h3, 4'h1, 64'h0, 64'h0);
        total++;
        if (valA !== 64'h55) begin bad++; $display("[TB] FAIL cmov_cnd1_R3 got=%h exp=%h", valA, 64'h55); end
    endtask

    // popq %rsp: both ports hit R4 and valM must win.
    task automatic test_popq_rsp();
        applyStimulus(4'hB, 1'b0, 4'h4, 4'hF, 64'h100, 64'h200);
        applyStimulus(4'h4, 1'b0, 4'h4, 4'hF, 64'h0, 64'h0);
        total++;
        if (valA !== 64'h200) begin bad++; $display("[TB] FAIL popq_rsp_collision got=%h exp=%h", valA, 64'h200); end
        total++;
        if (valB !== 64'h0) begin bad++; $display("[TB] FAIL rnone_read_B got=%h exp=%h", valB, 64'h0); end
    endtask

    // mrmovq writes only rA; halt and undefined icodes neither read nor write.
    task automatic test_mrmovq_halt();
        applyStimulus(4'h5, 1'b0, 4'h6, 4'h2, 64'h777, 64'hABCD);
        applyStimulus(4'h4, 1'b0, 4'h6, 4'h4, 64'h0, 64'h0);
        total++;
        if (valA !== 64'hABCD) begin bad++; $display("[TB] FAIL mrmovq_R6 got=%h exp=%h", valA, 64'hABCD); end
        total++;
        if (valB !== 64'h200) begin bad++; $display("[TB] FAIL mrmovq_R4_kept got=%h exp=%h", valB, 64'h200); end
        applyStimulus(4'h0, 1'b1, 4'h6, 4'h4, 64'h1234, 64'h5678);
        total++;
        if (valA !== 64'h0 || valB !== 64'h0) begin
            bad++; $display("[TB] FAIL halt_reads got=%h/%h exp=0/0", valA, valB);
        end
        applyStimulus(4'hC, 1'b1, 4'h6, 4'h4, 64'h1234, 64'h5678);
        total++;
        if (valA !== 64'h0 || valB !== 64'h0) begin
            bad++; $display("[TB] FAIL undef_reads got=%h/%h exp=0/0", valA, valB);
        end
        applyStimulus(4'h4, 1'b0, 4'h6, 4'h4, 64'h0, 64'h0);
        total++;
        if (valA !== 64'hABCD || valB !== 64'h200) begin
            bad++; $display("[TB] FAIL halt_no_write got=%h/%h exp=abcd/200", valA, valB);
        end
        applyStimulus(4'h4, 1'b0, 4'hF, 4'h6, 64'h0, 64'h0);
        total++;
        if (valA !== 64'h0 || valB !== 64'hABCD) begin
            bad++; $display("[TB] FAIL rnone_read_A got=%h/%h exp=0/abcd", valA, valB);
        end
    endtask

    // Reset between edges clears reads at once, blocks a write edge, and
    // normal writes resume after release.
    task automatic test_async_reset();
        applyStimulus(4'hB, 1'b0, 4'h8, 4'hF, 64'h200, 64'h0);
        total++;
        if (valA !== 64'h200) begin bad++; $display("[TB] FAIL pre_reset_R4 got=%h exp=%h", valA, 64'h200); end
        #2 reset = 1'b1;
        #1;
        total++;
        if (valA !== 64'h0 || valB !== 64'h0) begin
            bad++; $display("[TB] FAIL async_reset_reads got=%h/%h exp=0/0", valA, valB);
        end
        applyStimulus(4'h3, 1'b0, 4'h0, 4'h5, 64'h77, 64'h0);
        applyStimulus(4'h4, 1'b0, 4'h5, 4'h4, 64'h0, 64'h0);
        reset = 1'b0;
        #1;
        total++;
        if (valA !== 64'h0 || valB !== 64'h0) begin
            bad++; $display("[TB] FAIL reset_blocks_write got=%h/%h exp=0/0", valA, valB);
        end
        applyStimulus(4'h3, 1'b0, 4'h0, 4'h5, 64'h99, 64'h0);
        applyStimulus(4'h4, 1'b0, 4'h5, 4'h0, 64'h0, 64'h0);
        total++;
        if (valA !== 64'h99 || valB !== 64'h0) begin
            bad++; $display("[TB] FAIL resume_after_reset got=%h/%h exp=99/0", valA, valB);
        end
    endtask

    // Run all scenarios in order and report.
    initial begin
        test_reset();
        test_popq();
        test_irmovq_opq();
        test_cmov();
        test_popq_rsp();
        test_mrmovq_halt();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
